// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the generic inter-stage pipeline registers.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000;

  // Base bit offset of an operand lane inside a packed lane bus.
  function automatic int lane_base(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: pc, instr, NUM_OPS operand lanes and valid,
// with stall hold, flush bubble insertion and a saturating bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          NUM_OPS        = 3,
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter bit          BUBBLE_KEEP_PC = 1'b1,
  parameter int          CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      cnt_clr,
  input  logic                      in_valid,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               in_instr,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  output logic                      out_valid,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_instr,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [CNT_W-1:0]          bubble_cnt
);

  logic                      valid_q, valid_d;
  logic [31:0]               pc_q, pc_d;
  logic [31:0]               instr_q, instr_d;
  logic [NUM_OPS*DATA_W-1:0] ops_q, ops_d;
  logic                      bubble_evt;

  // Flush beats stall beats load; a load of an empty slot still carries its pc.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ops_d   = ops_q;
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = BUBBLE_KEEP_PC ? in_pc : RESET_PC;
      instr_d = NOP_INSTR;
      ops_d   = '0;
    end else if (!stall) begin
      pc_d = in_pc;
      if (in_valid) begin
        valid_d = 1'b1;
        instr_d = in_instr;
        for (int k = 0; k < NUM_OPS; k++) begin
          ops_d[lane_base(k, DATA_W) +: DATA_W] = in_ops[lane_base(k, DATA_W) +: DATA_W];
        end
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        ops_d   = '0;
      end
    end
  end

  // A stall holding an existing bubble does not count as a new one.
  assign bubble_evt = flush | (~stall & ~in_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ops_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ops_q   <= ops_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_evt),
    .clr   (cnt_clr),
    .count (bubble_cnt)
  );

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_ops   = ops_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg across four parameterisations sharing one stimulus.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, cnt_clr, in_valid;
  logic [31:0] in_pc, in_instr;
  logic [95:0] in_ops;
  logic [7:0]  in_ops_s;

  logic        m_valid, k_valid, c_valid, s_valid;
  logic [31:0] m_pc, k_pc, c_pc, s_pc;
  logic [31:0] m_instr, k_instr, c_instr, s_instr;
  logic [95:0] m_ops, k_ops, c_ops;
  logic [7:0]  s_ops;
  logic [15:0] m_cnt, k_cnt, s_cnt;
  logic [1:0]  c_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_main (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ops(in_ops),
    .out_valid(m_valid), .out_pc(m_pc), .out_instr(m_instr), .out_ops(m_ops),
    .bubble_cnt(m_cnt)
  );

  pipe_stage_reg #(.BUBBLE_KEEP_PC(1'b0)) u_nokeep (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ops(in_ops),
    .out_valid(k_valid), .out_pc(k_pc), .out_instr(k_instr), .out_ops(k_ops),
    .bubble_cnt(k_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ops(in_ops),
    .out_valid(c_valid), .out_pc(c_pc), .out_instr(c_instr), .out_ops(c_ops),
    .bubble_cnt(c_cnt)
  );

  pipe_stage_reg #(.NUM_OPS(1), .DATA_W(8)) u_small (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ops(in_ops_s),
    .out_valid(s_valid), .out_pc(s_pc), .out_instr(s_instr), .out_ops(s_ops),
    .bubble_cnt(s_cnt)
  );

  always @(posedge clk) begin
    if (!reset) assert (!$isunknown({stall, flush})) else $error("stall/flush unknown");
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
    in_pc = '0; in_instr = '0; in_ops = '0; in_ops_s = '0;
    step(); step();
    reset = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3ABC; in_instr = 32'hDEAD_BEEF;
    in_ops = {32'h3, 32'h2, 32'h1}; in_ops_s = 8'h5A;
    step();
    n_checks++;
    if (m_pc !== 32'h3ABC) begin n_fail++; $display("FAIL pre_reset_pc: got %h want %h", m_pc, 32'h3ABC); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (m_pc !== 32'h3000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", m_pc, 32'h3000); end
    n_checks++;
    if (m_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", m_instr); end
    n_checks++;
    if (m_ops !== 96'h0) begin n_fail++; $display("FAIL reset_ops: got %h want 0", m_ops); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_checks++;
    if (m_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", m_cnt); end
    n_checks++;
    if (s_ops !== 8'h0) begin n_fail++; $display("FAIL reset_small_ops: got %h want 0", s_ops); end
    #1 reset = 1'b0;
  endtask

  task automatic test_load();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
    in_pc = 32'h3004; in_instr = 32'h8C41_0004;
    in_ops = {32'h0000_0004, 32'h0000_0022, 32'h0000_0011};
    step();
    n_checks++;
    if (m_pc !== 32'h3004) begin n_fail++; $display("FAIL load_pc: got %h want %h", m_pc, 32'h3004); end
    n_checks++;
    if (m_instr !== 32'h8C41_0004) begin n_fail++; $display("FAIL load_instr: got %h want 8c410004", m_instr); end
    n_checks++;
    if (m_ops !== {32'h4, 32'h22, 32'h11}) begin n_fail++; $display("FAIL load_ops: got %h", m_ops); end
    n_checks++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b want 1", m_valid); end
    n_checks++;
    if (m_cnt !== 16'd0) begin n_fail++; $display("FAIL load_cnt: got %0d want 0", m_cnt); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_pc = 32'h3008; in_instr = 32'h0123_4567;
    in_ops = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001};
    step();
    stall = 1'b1; in_pc = 32'h300C; in_instr = 32'hFFFF_0000; in_ops = '1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (m_pc !== 32'h3008) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 3008", i, m_pc); end
      n_checks++;
      if (m_instr !== 32'h0123_4567) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want 01234567", i, m_instr); end
      n_checks++;
      if (m_ops !== {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001}) begin
        n_fail++; $display("FAIL stall_ops[%0d]: got %h", i, m_ops);
      end
      n_checks++;
      if (m_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, m_valid); end
      n_checks++;
      if (m_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_cnt[%0d]: got %0d want 0", i, m_cnt); end
    end
  endtask

  task automatic test_flush();
    stall = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3010; in_instr = 32'h1111_2222;
    step();
    flush = 1'b0;
    n_checks++;
    if (m_pc !== 32'h3010) begin n_fail++; $display("FAIL flush_keep_pc: got %h want 3010", m_pc); end
    n_checks++;
    if (k_pc !== 32'h3000) begin n_fail++; $display("FAIL flush_reset_pc: got %h want 3000", k_pc); end
    n_checks++;
    if (m_instr !== 32'h0) begin n_fail++; $display("FAIL flush_instr: got %h want 0", m_instr); end
    n_checks++;
    if (m_ops !== 96'h0) begin n_fail++; $display("FAIL flush_ops: got %h want 0", m_ops); end
    n_checks++;
    if (m_valid !== 1'b0 || k_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b/%b want 0/0", m_valid, k_valid);
    end
    n_checks++;
    if (m_cnt !== 16'd1 || k_cnt !== 16'd1) begin
      n_fail++; $display("FAIL flush_cnt: got %0d/%0d want 1/1", m_cnt, k_cnt);
    end
  endtask

  task automatic test_counter();
    logic [1:0] exp_c [5];
    exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3; exp_c[4] = 2'd3;
    stall = 1'b1; flush = 1'b0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_checks++;
    if (c_cnt !== 2'd0 || m_cnt !== 16'd0) begin
      n_fail++; $display("FAIL cnt_clear: got %0d/%0d want 0/0", c_cnt, m_cnt);
    end
    stall = 1'b0; in_valid = 1'b0; in_pc = 32'h3040; in_instr = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (c_cnt !== exp_c[i]) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, c_cnt, exp_c[i]); end
    end
    n_checks++;
    if (m_cnt !== 16'd5) begin n_fail++; $display("FAIL wide_cnt: got %0d want 5", m_cnt); end
    n_checks++;
    if (m_pc !== 32'h3040 || m_instr !== 32'h0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_load: got pc=%h instr=%h v=%b want 3040/0/0", m_pc, m_instr, m_valid);
    end
    flush = 1'b1; cnt_clr = 1'b1;
    step();
    flush = 1'b0; cnt_clr = 1'b0;
    n_checks++;
    if (c_cnt !== 2'd0 || m_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clr_over_event: got %0d/%0d want 0/0", c_cnt, m_cnt);
    end
  endtask

  task automatic test_async_reset();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b1; in_pc = 32'h3020; in_instr = 32'h2002_0001;
    step();
    n_checks++;
    if (m_valid !== 1'b1 || m_pc !== 32'h3020) begin
      n_fail++; $display("FAIL mid_load: got v=%b pc=%h want 1/3020", m_valid, m_pc);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_pc !== 32'h3000 || m_instr !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: got v=%b pc=%h instr=%h want 0/3000/0", m_valid, m_pc, m_instr);
    end
    #1 reset = 1'b0;
    in_pc = 32'h3024; in_instr = 32'h3333_4444;
    step();
    n_checks++;
    if (m_valid !== 1'b1 || m_pc !== 32'h3024 || m_instr !== 32'h3333_4444) begin
      n_fail++; $display("FAIL post_reset_load: got v=%b pc=%h instr=%h want 1/3024/33334444", m_valid, m_pc, m_instr);
    end
  endtask

  task automatic test_sweep();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b1; in_pc = 32'h3028; in_ops_s = 8'hA5;
    step();
    n_checks++;
    if (s_ops !== 8'hA5) begin n_fail++; $display("FAIL small_ops: got %h want a5", s_ops); end
    n_checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h3028) begin
      n_fail++; $display("FAIL small_meta: got v=%b pc=%h want 1/3028", s_valid, s_pc);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_counter();
    test_async_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
